// File: rtl/wb_dma_pkg.sv
// ---------------------------------------------------------------------------
// wb_dma_pkg : shared types and constants for the Wishbone read-DMA master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } dma_state_e;

  localparam int          TIMEOUT_CYC = 256;
  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [31:0] ADR_INC     = 32'd4;

endpackage

`default_nettype wire

// File: rtl/dma_rd_fifo.sv
// ---------------------------------------------------------------------------
// dma_rd_fifo : synchronous FIFO holding read words plus their last tag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/wb_dma_reader.sv
// ---------------------------------------------------------------------------
// wb_dma_reader : Wishbone single-beat read DMA into a valid/ready stream
// Optional bus timeout: WB_DMA_RD_TIMEOUT_EN                        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_dma_reader
  import wb_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      base_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_stb_o,
  output logic             wbm_cyc_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_dat_o,
  output logic [31:0]      wbm_adr_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             m_tvalid,
  output logic [31:0]      m_tdata,
  output logic             m_tlast,
  input  logic             m_tready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e       state;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      adr;
  logic             stb;
  logic             busy;
  logic             done;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [32:0]      fifo_head;
  logic             push;
  logic             pop;
  logic             fifo_clr;
  logic             slot_free;
  logic             flush_done;

  assign push       = (state == ST_REQ) && wbm_ack_i;
  assign pop        = m_tvalid && m_tready;
  assign slot_free  = !fifo_full || pop;
  assign flush_done = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

`ifdef WB_DMA_RD_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err;
  assign fifo_clr = (state == ST_REQ) && !wbm_ack_i && (tmo_cnt == 8'(TIMEOUT_CYC - 1));
  assign err_o    = err;
`else
  assign fifo_clr = 1'b0;
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= ST_IDLE;
      remaining <= '0;
      adr       <= '0;
      stb       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef WB_DMA_RD_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            adr       <= base_adr_i & ~32'h3;
            remaining <= len_i;
            busy      <= 1'b1;
`ifdef WB_DMA_RD_TIMEOUT_EN
            tmo_cnt   <= '0;
            err       <= 1'b0;
`endif
            if (len_i == '0) begin
              state <= ST_FLUSH;
            end else begin
              state <= ST_REQ;
              stb   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (wbm_ack_i) begin
            adr       <= adr + ADR_INC;
            remaining <= remaining - 1'b1;
            stb       <= 1'b0;
            state     <= (remaining == LEN_W'(1)) ? ST_FLUSH : ST_GAP;
          end
`ifdef WB_DMA_RD_TIMEOUT_EN
          else if (fifo_clr) begin
            // Abandon the transfer: buffered words are dropped, DONE still pulses.
            stb   <= 1'b0;
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        ST_GAP, ST_HOLD: begin
          if (slot_free) begin
            state <= ST_REQ;
            stb   <= 1'b1;
`ifdef WB_DMA_RD_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          stb   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  dma_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .clr   (fifo_clr),
    .push  (push),
    .din   ({(remaining == LEN_W'(1)), wbm_dat_i}),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy_o    = busy;
  assign done_o    = done;
  assign wbm_stb_o = stb;
  assign wbm_cyc_o = stb;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = WB_SEL_ALL;
  assign wbm_dat_o = 32'h0;
  assign wbm_adr_o = adr;
  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = fifo_head[31:0];
  assign m_tlast   = fifo_head[32] && !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_wb_dma_reader.sv
// ---------------------------------------------------------------------------
// tb_wb_dma_reader : directed self-checking bench for wb_dma_reader
// Timeout scenario only when WB_DMA_RD_TIMEOUT_EN is defined        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_dma_reader;

  localparam logic [31:0] DKEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [11:0] len_in = '0;
  logic        busy, done, err;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_o, adr;
  logic        ack;
  logic [31:0] dat_i;
  logic        tvalid, tlast;
  logic [31:0] tdata;
  logic        tready = 1'b0;
  logic        ack_en = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_adr[$];
  int          rd_cyc[$];
  logic [31:0] st_data[$];
  logic        st_last[$];
  int          done_cyc;
  int          reads_before;
  logic        busy1, busy2;
  logic [31:0] snap_data;
  logic        snap_stb;

  always #5 clk = ~clk;

  // Slave acknowledges in the same cycle and returns an address-derived word.
  assign ack   = stb & cyc & ack_en;
  assign dat_i = adr ^ DKEY;

  wb_dma_reader #(.FIFO_DEPTH(4), .LEN_W(12)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .start_i    (start),
    .base_adr_i (base_adr),
    .len_i      (len_in),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .wbm_stb_o  (stb),
    .wbm_cyc_o  (cyc),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_dat_o  (dat_o),
    .wbm_adr_o  (adr),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (dat_i),
    .m_tvalid   (tvalid),
    .m_tdata    (tdata),
    .m_tlast    (tlast),
    .m_tready   (tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start at the negedge of cycle 0, then sample each cycle n at its negedge.
  task automatic run_xfer(input logic [31:0] base, input int len, input int ready_at,
                          input int max_cyc);
    rd_adr.delete(); rd_cyc.delete(); st_data.delete(); st_last.delete();
    done_cyc = -1; reads_before = 0; busy1 = 1'b0; busy2 = 1'b0;
    snap_data = '0; snap_stb = 1'b1;
    @(negedge clk);
    base_adr = base;
    len_in   = 12'(len);
    start    = 1'b1;
    tready   = (ready_at <= 0);
    for (int n = 1; n <= max_cyc && done_cyc < 0; n++) begin
      @(negedge clk);
      start  = 1'b0;
      tready = (n >= ready_at);
      if (stb && ack) begin
        rd_adr.push_back(adr);
        rd_cyc.push_back(n);
        if (n < ready_at) reads_before++;
      end
      if (tvalid && tready) begin
        st_data.push_back(tdata);
        st_last.push_back(tlast);
      end
      if (done) done_cyc = n;
      if (n == 1) busy1 = busy;
      if (n == 2) busy2 = busy;
      if (n == 29) begin
        snap_data = tdata;
        snap_stb  = stb;
      end
    end
    if (done_cyc < 0) check("done_bound", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int len);
    check({tag, "_nwords"}, 32'(st_data.size()), 32'(len));
    check({tag, "_nreads"}, 32'(rd_adr.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      if (i < st_data.size()) begin
        check({tag, "_data"}, st_data[i], (base + 32'(4 * i)) ^ DKEY);
        check({tag, "_last"}, 32'(st_last[i]), 32'(i == len - 1));
      end
      if (i < rd_adr.size()) check({tag, "_adr"}, rd_adr[i], base + 32'(4 * i));
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_we", 32'(we), 32'd0);
    check("rst_dat_o", dat_o, 32'd0);
    rst_n = 1'b1;

    // len 3, same-cycle ack, ready always
    run_xfer(32'h3800_0000, 3, 0, 50);
    check_stream("t1", 32'h3800_0000, 3);
    for (int i = 0; i < 3; i++)
      if (i < rd_cyc.size()) check("t1_rdcyc", 32'(rd_cyc[i]), 32'(1 + 2 * i));
    check("t1_busy1", 32'(busy1), 32'd1);
    check("t1_done", 32'(done_cyc), 32'd7);

    // len 8 with FIFO back-pressure until cycle 30
    run_xfer(32'h1000_0000, 8, 30, 100);
    check("t2_reads_before", 32'(reads_before), 32'd4);
    check("t2_stb29", 32'(snap_stb), 32'd0);
    check("t2_hold_data", snap_data, 32'h1000_0000 ^ DKEY);
    if (rd_cyc.size() > 4) check("t2_rd5_cyc", 32'(rd_cyc[4]), 32'd31);
    check_stream("t2", 32'h1000_0000, 8);
    check("t2_done", 32'(done_cyc), 32'd39);

    // Address wrap
    run_xfer(32'hFFFF_FFFC, 2, 0, 50);
    check_stream("t3", 32'hFFFF_FFFC, 2);
    check("t3_done", 32'(done_cyc), 32'd5);

    // Zero length
    run_xfer(32'h2222_0000, 0, 0, 20);
    check("t4_reads", 32'(rd_adr.size()), 32'd0);
    check("t4_done", 32'(done_cyc), 32'd2);
    check("t4_busy1", 32'(busy1), 32'd1);
    check("t4_busy2", 32'(busy2), 32'd0);

    // Reset while word 2 of 5 is on the bus
    @(negedge clk);
    base_adr = 32'h2000_0000; len_in = 12'd5; start = 1'b1; tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ack_en = 1'b0;
    @(negedge clk);
    check("t5_pre_stb", 32'(stb), 32'd1);
    check("t5_pre_adr", adr, 32'h2000_0004);
    check("t5_pre_tvalid", 32'(tvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_stb", 32'(stb), 32'd0);
    check("t5_cyc", 32'(cyc), 32'd0);
    check("t5_tvalid", 32'(tvalid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t5_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1; ack_en = 1'b1;
    run_xfer(32'h3800_0000, 3, 0, 50);
    check_stream("t5b", 32'h3800_0000, 3);
    check("t5b_done", 32'(done_cyc), 32'd7);

`ifdef WB_DMA_RD_TIMEOUT_EN
    ack_en = 1'b0;
    run_xfer(32'h4000_0000, 2, 0, 300);
    check("t6_done", 32'(done_cyc), 32'd257);
    check("t6_err", 32'(err), 32'd1);
    check("t6_stb", 32'(stb), 32'd0);
    check("t6_words", 32'(st_data.size()), 32'd0);
    ack_en = 1'b1;
    run_xfer(32'h4000_0000, 1, 0, 20);
    check("t6_err_clr", 32'(err), 32'd0);
    check_stream("t6b", 32'h4000_0000, 1);
`else
    check("t6_err_tied", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_dma_reader.md
# wb_dma_reader

Wishbone read-DMA master feeding the DMA port of the RAM arbiter. On a start pulse it fetches `len_i` consecutive 32-bit words from RAM starting at `base_adr_i`. It buffers them in a small FIFO and presents them on a valid/ready stream with `last` marking the final word. It issues one single-beat Wishbone read at a time and releases the bus for one cycle between reads, so the arbiter can re-arbitrate in favour of the CPU.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: buffer depth in words; power of two, 2..16.
- `LEN_W`, 12: width of the transfer-length field.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle start request; ignored while `busy_o`=1.
- `base_adr_i` in 32: start byte address, sampled on start; bits [1:0] forced to 0.
- `len_i` in LEN_W: word count, sampled on start; 0 is legal.
- `busy_o` out 1: transfer in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: timeout error, sticky until next accepted start (macro only).
- `wbm_stb_o` out 1: Wishbone strobe.
- `wbm_cyc_o` out 1: Wishbone cycle.
- `wbm_we_o` out 1: write enable; constant 0.
- `wbm_sel_o` out 4: byte select; constant 4'hF.
- `wbm_dat_o` out 32: write data; constant 0.
- `wbm_adr_o` out 32: read byte address.
- `wbm_ack_i` in 1: Wishbone acknowledge.
- `wbm_dat_i` in 32: Wishbone read data.
- `m_tvalid` out 1: stream word valid.
- `m_tdata` out 32: stream word data.
- `m_tlast` out 1: final word of the transfer.
- `m_tready` in 1: downstream accepts the word.

## Operation
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters 0. `wbm_sel_o` is the constant 4'hF and is not a reset-dependent output.
- FSM states:
  - IDLE: a start is accepted → REQ, or → FLUSH when `len_i`=0.
  - REQ: `stb`/`cyc` held high and address stable until ack. On ack the word is pushed to the FIFO, the address increments by 4 (wraps modulo 2^32), and the remaining count decrements.
    - After ack → GAP.
    - If remaining count reaches 0 → FLUSH.
  - GAP: exactly one cycle with `stb`/`cyc` low.
    - → REQ when the FIFO has at least one free slot (counting the occupancy after this cycle's pop).
    - Otherwise → HOLD.
  - HOLD: `stb`/`cyc` low; → REQ when a slot frees.
  - FLUSH: wait until the FIFO is empty and the last word has been handshaken → DONE.
  - DONE: `done_o`=1 for one cycle, `busy_o` drops → IDLE.
- At most one outstanding read. A request is never issued without a guaranteed free FIFO slot, so the FIFO never overflows.
- `m_tlast`=1 exactly when the word at the FIFO head is word index `len-1`. It is tracked by a tag bit stored with each FIFO entry.
- Simultaneous FIFO push and pop leaves the occupancy unchanged.
- Reset mid-transfer: `stb`/`cyc` drop asynchronously, FIFO contents are discarded, and no `done_o` pulse occurs.

## Timing
- Start accepted at edge 0 → in cycle 1, `busy_o`=1, `stb`=`cyc`=1, `adr`=base.
- Ack in cycle k (same-cycle ack is possible) → word visible on `m_tvalid`/`m_tdata` in cycle k+1; `stb`=0 in cycle k+1; next request in cycle k+2 if space.
- Back-to-back throughput is therefore at most 1 word / 2 cycles with a same-cycle ack.
- Stream: a word transfers when `m_tvalid` & `m_tready`. `m_tdata` and `m_tlast` are held stable while `m_tvalid`=1 and `m_tready`=0.
- `done_o` asserts the cycle after the `last` handshake.
- `len_i`=0: `done_o` in cycle 2, no bus activity.

## Configuration
- `WB_DMA_RD_TIMEOUT_EN` defined:
  - An 8-bit counter runs while in REQ without ack.
  - After 256 cycles it drops `stb`/`cyc`, sets `err_o`, flushes the FIFO without emitting the remaining words, and passes through DONE (`done_o` pulses).
  - `err_o` clears on the next accepted start.
- Not defined: `err_o` is tied to 0 and REQ waits indefinitely.

## Structure
- Package `wb_dma_pkg`: FSM state enum (IDLE, REQ, GAP, HOLD, FLUSH, DONE), `TIMEOUT_CYC`=256, `WB_SEL_ALL`=4'hF, address increment constant 4.
- Sub-module `dma_rd_fifo`: synchronous FIFO of width 33 (data plus last tag) and depth `FIFO_DEPTH`, with push, pop, full, empty, and count outputs.

## Test plan
- Base 0x3800_0000, len 3, ack same cycle, `m_tready`=1 → reads at 0x3800_0000/04/08 in cycles 1, 3, 5; `tlast` only on the 3rd word; `done_o` in cycle 7.
- len 8, FIFO_DEPTH 4, `m_tready`=0 until cycle 30 → exactly 4 reads issued, then `stb` stays low; the remaining 4 reads follow once ready rises; stream data is in order.
- Base 0xFFFF_FFFC, len 2 → second address is 0x0000_0000.
- len 0 → no `stb`; `done_o` in cycle 2; `busy_o` high only in cycle 1.
- Reset asserted while `stb`=1 on word 2 of 5 → `stb`/`cyc`/`m_tvalid` go to 0 immediately, no `done_o`; a subsequent start behaves normally.
- With `WB_DMA_RD_TIMEOUT_EN`, ack withheld → `stb` drops after 256 cycles, `err_o`=1, `done_o` pulses; the next start clears `err_o`.
